// File: rtl/sdram_word_bridge.sv
// 32-bit word requests split into two 16-bit Avalon-MM transfers.
// Optional read watchdog and sdram_error port: SDRAM_BRIDGE_TIMEOUT_EN.
module sdram_word_bridge #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        avm_clk,
   input  logic        avm_rst,
   input  logic [22:0] sdram_addr,
   input  logic        sdram_read,
   input  logic        sdram_write,
   input  logic [31:0] sdram_writedata,
   output logic [31:0] sdram_readdata,
   output logic        sdram_finished,
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
   output logic        sdram_error,
`endif
   output logic [23:0] mem_address,
   output logic        mem_read,
   output logic        mem_write,
   output logic [15:0] mem_writedata,
   output logic [1:0]  mem_byteenable,
   input  logic [15:0] mem_readdata,
   input  logic        mem_readdatavalid,
   input  logic        mem_waitrequest
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_LO,
      S_WR_HI,
      S_RD_LO,
      S_RD_HI,
      S_RD_WAIT,
      S_DONE
   } state_t;

   state_t      r_state;
   logic [22:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_beat;
   logic [15:0] r_asm_lo;
   logic        w_beat_ok;

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
   localparam int WD_W = ($clog2(TIMEOUT_CYCLES) > 0) ?
                         $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0] r_wd_cnt;
`endif

   // Beats can land while the high-half read is still being issued.
   assign w_beat_ok = mem_readdatavalid &&
                      (r_state inside {S_RD_LO, S_RD_HI, S_RD_WAIT});

   always_ff @(posedge avm_clk) begin
      if (avm_rst) begin
         r_state        <= S_IDLE;
         r_addr         <= '0;
         r_wdata        <= '0;
         r_beat         <= 1'b0;
         r_asm_lo       <= '0;
         sdram_readdata <= '0;
         sdram_finished <= 1'b0;
         mem_address    <= '0;
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
         mem_writedata  <= '0;
         mem_byteenable <= 2'b00;
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
         sdram_error    <= 1'b0;
         r_wd_cnt       <= '0;
`endif
      end else begin
         sdram_finished <= 1'b0;
         if (w_beat_ok) begin
            r_beat <= ~r_beat;
            if (!r_beat) r_asm_lo <= mem_readdata;
         end
         unique case (r_state)
            S_IDLE: begin
               if (sdram_write) begin
                  r_addr         <= sdram_addr;
                  r_wdata        <= sdram_writedata;
                  mem_write      <= 1'b1;
                  mem_address    <= {sdram_addr, 1'b0};
                  mem_writedata  <= sdram_writedata[15:0];
                  mem_byteenable <= 2'b11;
                  r_state        <= S_WR_LO;
               end else if (sdram_read) begin
                  r_addr         <= sdram_addr;
                  r_beat         <= 1'b0;
                  mem_read       <= 1'b1;
                  mem_address    <= {sdram_addr, 1'b0};
                  mem_byteenable <= 2'b11;
                  r_state        <= S_RD_LO;
               end
            end
            S_WR_LO: begin
               if (!mem_waitrequest) begin
                  mem_address   <= {r_addr, 1'b1};
                  mem_writedata <= r_wdata[31:16];
                  r_state       <= S_WR_HI;
               end
            end
            S_WR_HI: begin
               if (!mem_waitrequest) begin
                  mem_write      <= 1'b0;
                  mem_byteenable <= 2'b00;
                  sdram_finished <= 1'b1;
                  r_state        <= S_DONE;
               end
            end
            S_RD_LO: begin
               if (!mem_waitrequest) begin
                  mem_address <= {r_addr, 1'b1};
                  r_state     <= S_RD_HI;
               end
            end
            S_RD_HI: begin
               if (!mem_waitrequest) begin
                  mem_read       <= 1'b0;
                  mem_byteenable <= 2'b00;
                  r_state        <= S_RD_WAIT;
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
                  r_wd_cnt       <= '0;
`endif
               end
            end
            S_RD_WAIT: begin
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
               if (r_wd_cnt == WD_LIM) begin
                  sdram_readdata <= 32'hDEAD_BEEF;
                  sdram_error    <= 1'b1;
                  sdram_finished <= 1'b1;
                  r_state        <= S_DONE;
               end else begin
                  r_wd_cnt <= r_wd_cnt + 1'b1;
               end
`else
               r_state <= S_RD_WAIT;
`endif
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
         // A real second beat always wins over the watchdog.
         if (w_beat_ok && r_beat) begin
            sdram_readdata <= {mem_readdata, r_asm_lo};
            sdram_finished <= 1'b1;
            mem_read       <= 1'b0;
            mem_byteenable <= 2'b00;
            r_state        <= S_DONE;
         end
      end
   end

endmodule

// File: tb/tb_sdram_word_bridge.sv
// Bench for sdram_word_bridge: directed timing plus random ops
// against a word-level memory reference and a halfword slave model.
module tb_sdram_word_bridge;

   logic        avm_clk = 1'b0;
   logic        avm_rst = 1'b1;
   logic [22:0] sdram_addr = '0;
   logic        sdram_read = 1'b0;
   logic        sdram_write = 1'b0;
   logic [31:0] sdram_writedata = '0;
   logic [31:0] sdram_readdata;
   logic        sdram_finished;
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
   logic        sdram_error;
`endif
   logic [23:0] mem_address;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_writedata;
   logic [1:0]  mem_byteenable;
   logic [15:0] mem_readdata;
   logic        mem_readdatavalid;
   logic        mem_waitrequest;

   logic        slv_en = 1'b0;
   logic        s_wr = 1'b0;
   logic        s_rv = 1'b0;
   logic [15:0] s_rd = '0;
   logic        d_wr = 1'b0;
   logic        d_rv = 1'b0;
   logic [15:0] d_rd = '0;

   assign mem_waitrequest   = slv_en ? s_wr : d_wr;
   assign mem_readdatavalid = slv_en ? s_rv : d_rv;
   assign mem_readdata      = slv_en ? s_rd : d_rd;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic        w;
      logic [23:0] a;
      logic [15:0] d;
   } ent_t;
   typedef struct {
      int          due;
      logic [15:0] d;
   } rsp_t;

   ent_t        log_q[$];
   rsp_t        pend_q[$];
   logic [15:0] smem[logic [23:0]];
   logic [31:0] ref_mem[logic [22:0]];
   logic [31:0] last_rd = '0;
   int          last_due = 0;
   ent_t        se;
   rsp_t        sr;

   sdram_word_bridge #(.TIMEOUT_CYCLES(16)) dut (
      .avm_clk           (avm_clk),
      .avm_rst           (avm_rst),
      .sdram_addr        (sdram_addr),
      .sdram_read        (sdram_read),
      .sdram_write       (sdram_write),
      .sdram_writedata   (sdram_writedata),
      .sdram_readdata    (sdram_readdata),
      .sdram_finished    (sdram_finished),
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
      .sdram_error       (sdram_error),
`endif
      .mem_address       (mem_address),
      .mem_read          (mem_read),
      .mem_write         (mem_write),
      .mem_writedata     (mem_writedata),
      .mem_byteenable    (mem_byteenable),
      .mem_readdata      (mem_readdata),
      .mem_readdatavalid (mem_readdatavalid),
      .mem_waitrequest   (mem_waitrequest)
   );

   always #5 avm_clk = ~avm_clk;
   always @(posedge avm_clk) cyc <= cyc + 1;

   // Halfword SDRAM slave: random stalls, in-order read latency 1..4.
   always @(negedge avm_clk) begin
      if (!slv_en) begin
         s_wr = 1'b0;
         s_rv = 1'b0;
         last_due = 0;
         pend_q.delete();
      end else begin
         s_wr = ($urandom_range(0, 2) == 0);
         if (mem_write && !s_wr) begin
            smem[mem_address] = mem_writedata;
            se.w = 1'b1; se.a = mem_address; se.d = mem_writedata;
            log_q.push_back(se);
         end
         if (mem_read && !s_wr) begin
            sr.d = smem.exists(mem_address) ? smem[mem_address] : 16'h0;
            sr.due = cyc + int'($urandom_range(1, 4));
            if (sr.due <= last_due) sr.due = last_due + 1;
            last_due = sr.due;
            pend_q.push_back(sr);
            se.w = 1'b0; se.a = mem_address; se.d = 16'h0;
            log_q.push_back(se);
         end
         s_rv = 1'b0;
         if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            s_rv = 1'b1;
            s_rd = pend_q[0].d;
            void'(pend_q.pop_front());
         end
      end
   end

   task automatic do_op(input logic wr, input logic [22:0] a,
                        input logic [31:0] d, output bit ok);
      @(negedge avm_clk);
      sdram_addr = a;
      sdram_writedata = d;
      sdram_write = wr;
      sdram_read = ~wr;
      ok = 1'b0;
      for (int n = 0; n < 300; n++) begin
         @(negedge avm_clk);
         if (sdram_finished) begin
            ok = 1'b1;
            break;
         end
      end
      sdram_write = 1'b0;
      sdram_read = 1'b0;
   endtask

   task automatic test_reset;
      avm_rst = 1'b1;
      repeat (3) @(negedge avm_clk);
      avm_rst = 1'b0;
      @(negedge avm_clk);
      checks++;
      if ({mem_read, mem_write, sdram_finished, mem_byteenable} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 00000",
                  {mem_read, mem_write, sdram_finished, mem_byteenable});
      end
      checks++;
      if ({mem_address, mem_writedata} !== 40'h0) begin
         errors++;
         $display("FAIL reset_bus got %h want 0", {mem_address, mem_writedata});
      end
      checks++;
      if (sdram_readdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_rdata got %h want 0", sdram_readdata);
      end
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
      checks++;
      if (sdram_error !== 1'b0) begin
         errors++;
         $display("FAIL reset_error got %b want 0", sdram_error);
      end
`endif
   endtask

   task automatic test_basic_write;
      logic [41:0] act, exp;
      slv_en = 1'b0;
      d_wr = 1'b0;
      @(negedge avm_clk);
      sdram_addr = 23'h000005;
      sdram_writedata = 32'hA1B2C3D4;
      sdram_write = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge avm_clk);
         act = {sdram_finished, mem_write, mem_address, mem_writedata};
         exp = {2'b01, 24'h00000A, 16'hC3D4};
         if (k == 2) exp = {2'b01, 24'h00000B, 16'hA1B2};
         if (k == 3) exp = {2'b10, mem_address, mem_writedata};
         if (k == 4) exp = {2'b00, mem_address, mem_writedata};
         if (k >= 3) act[39:0] = exp[39:0];
         checks++;
         if (act !== exp) begin
            errors++;
            $display("FAIL basic_write_t%0d got %h want %h", k, act, exp);
         end
         if (k == 3) sdram_write = 1'b0;
      end
   endtask

   task automatic test_write_wait;
      logic [42:0] act, exp;
      slv_en = 1'b0;
      @(negedge avm_clk);
      sdram_addr = 23'h000005;
      sdram_writedata = 32'hA1B2C3D4;
      sdram_write = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge avm_clk);
         d_wr = (k <= 3);
         act = {sdram_finished, mem_write, mem_byteenable[0],
                mem_address, mem_writedata};
         exp = {3'b011, 24'h00000A, 16'hC3D4};
         if (k == 5) exp = {3'b011, 24'h00000B, 16'hA1B2};
         if (k == 6) exp = {3'b100, mem_address, mem_writedata};
         if (k == 7) exp = {3'b000, mem_address, mem_writedata};
         if (k >= 6) act[39:0] = exp[39:0];
         checks++;
         if (act !== exp) begin
            errors++;
            $display("FAIL write_wait_t%0d got %h want %h", k, act, exp);
         end
         if (k == 6) sdram_write = 1'b0;
      end
      d_wr = 1'b0;
   endtask

   task automatic test_read;
      slv_en = 1'b0;
      @(negedge avm_clk);
      sdram_addr = 23'h7FFFFF;
      sdram_read = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge avm_clk);
         d_rv = 1'b0;
         checks++;
         case (k)
            1: if ({mem_read, mem_byteenable, mem_address} !== {3'b111, 24'hFFFFFE}) begin
               errors++;
               $display("FAIL read_lo got %h", {mem_read, mem_address});
            end
            2: if ({mem_read, mem_address} !== {1'b1, 24'hFFFFFF}) begin
               errors++;
               $display("FAIL read_hi got %h", {mem_read, mem_address});
            end
            3, 4: if ({sdram_finished, mem_read} !== 2'b00) begin
               errors++;
               $display("FAIL read_wait_t%0d got %b want 00", k,
                        {sdram_finished, mem_read});
            end
            default: if ({sdram_finished, sdram_readdata} !==
                         {(k == 5), 32'h12345678}) begin
               errors++;
               $display("FAIL read_done_t%0d got %h want %h", k,
                        {sdram_finished, sdram_readdata},
                        {(k == 5), 32'h12345678});
            end
         endcase
         if (k == 2) begin d_rv = 1'b1; d_rd = 16'h5678; end
         if (k == 4) begin d_rv = 1'b1; d_rd = 16'h1234; end
         if (k == 5) sdram_read = 1'b0;
      end
   endtask

   task automatic test_reset_mid_read;
      slv_en = 1'b0;
      @(negedge avm_clk);
      sdram_addr = 23'($urandom);
      sdram_read = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge avm_clk);
         d_rv = 1'b0;
         if (k == 3) avm_rst = 1'b1;
         if (k == 4) begin
            avm_rst = 1'b0;
            sdram_read = 1'b0;
            checks++;
            if ({mem_read, mem_write, mem_byteenable, mem_address,
                 mem_writedata} !== 44'h0) begin
               errors++;
               $display("FAIL midrst_bus got %h want 0",
                        {mem_read, mem_write, mem_address});
            end
         end
         if (k == 4 || k == 5) begin
            d_rv = 1'b1;
            d_rd = 16'($urandom);
         end
         if (k >= 4) begin
            checks++;
            if ({sdram_finished, sdram_readdata} !== 33'h0) begin
               errors++;
               $display("FAIL midrst_stray_t%0d got %h want 0", k,
                        {sdram_finished, sdram_readdata});
            end
         end
      end
      last_rd = 32'h0;
   endtask

   task automatic test_simultaneous;
      logic [22:0] a;
      logic [31:0] w;
      bit ok1, ok2;
      slv_en = 1'b1;
      log_q.delete();
      a = 23'($urandom);
      w = $urandom;
      ok1 = 0;
      ok2 = 0;
      @(negedge avm_clk);
      sdram_addr = a;
      sdram_writedata = w;
      sdram_write = 1'b1;
      sdram_read = 1'b1;
      for (int n = 0; n < 300 && !ok1; n++) begin
         @(negedge avm_clk);
         if (sdram_finished) ok1 = 1;
      end
      sdram_write = 1'b0;
      checks++;
      if (!ok1 || log_q.size() != 2 || !log_q[0].w || !log_q[1].w ||
          log_q[0].a != {a, 1'b0} || log_q[1].d != w[31:16]) begin
         errors++;
         $display("FAIL simul_write_first ok=%0d entries=%0d want 2 writes",
                  ok1, log_q.size());
      end
      for (int n = 0; n < 300 && !ok2; n++) begin
         @(negedge avm_clk);
         if (sdram_finished) ok2 = 1;
      end
      sdram_read = 1'b0;
      checks++;
      if (!ok2 || sdram_readdata !== w) begin
         errors++;
         $display("FAIL simul_read ok=%0d got %h want %h",
                  ok2, sdram_readdata, w);
      end
      checks++;
      if (log_q.size() != 4 || log_q[2].w || log_q[3].w ||
          log_q[3].a != {a, 1'b1}) begin
         errors++;
         $display("FAIL simul_read_bus entries=%0d want 4", log_q.size());
      end
      ref_mem[a] = w;
      last_rd = w;
   endtask

   task automatic test_random;
      logic [22:0] pool[8];
      logic [22:0] a;
      logic [31:0] d, exp;
      logic        wr;
      bit          ok;
      slv_en = 1'b1;
      pool[0] = 23'h000000;
      pool[1] = 23'h7FFFFF;
      for (int i = 2; i < 8; i++) pool[i] = 23'($urandom);
      for (int i = 0; i < 40; i++) begin
         a = pool[$urandom_range(0, 7)];
         d = $urandom;
         wr = ($urandom_range(0, 1) == 1);
         log_q.delete();
         do_op(wr, a, d, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL rand_op%0d_timeout wr=%0d addr=%h", i, wr, a);
         end
         if (wr) begin
            ref_mem[a] = d;
            checks++;
            if (log_q.size() != 2 ||
                log_q[0].a != {a, 1'b0} || log_q[0].d != d[15:0] ||
                log_q[1].a != {a, 1'b1} || log_q[1].d != d[31:16]) begin
               errors++;
               $display("FAIL rand_op%0d_wbus entries=%0d addr=%h data=%h",
                        i, log_q.size(), a, d);
            end
            checks++;
            if (sdram_readdata !== last_rd) begin
               errors++;
               $display("FAIL rand_op%0d_sticky got %h want %h",
                        i, sdram_readdata, last_rd);
            end
         end else begin
            exp = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
            checks++;
            if (sdram_readdata !== exp) begin
               errors++;
               $display("FAIL rand_op%0d_rdata addr=%h got %h want %h",
                        i, a, sdram_readdata, exp);
            end
            checks++;
            if (log_q.size() != 2 || log_q[0].w || log_q[1].w ||
                log_q[0].a != {a, 1'b0} || log_q[1].a != {a, 1'b1}) begin
               errors++;
               $display("FAIL rand_op%0d_rbus entries=%0d addr=%h",
                        i, log_q.size(), a);
            end
            last_rd = exp;
         end
      end
   endtask

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
   task automatic test_timeout;
      int  fin_k;
      bit  ok;
      slv_en = 1'b0;
      d_rv = 1'b0;
      fin_k = -1;
      @(negedge avm_clk);
      sdram_addr = 23'($urandom);
      sdram_read = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         @(negedge avm_clk);
         if (sdram_finished && fin_k < 0) begin
            fin_k = k;
            sdram_read = 1'b0;
         end
      end
      sdram_read = 1'b0;
      checks++;
      if (fin_k != 19) begin
         errors++;
         $display("FAIL timeout_cycle got %0d want 19", fin_k);
      end
      checks++;
      if ({sdram_error, sdram_readdata} !== {1'b1, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL timeout_value got %h want 1deadbeef",
                  {sdram_error, sdram_readdata});
      end
      slv_en = 1'b1;
      do_op(1'b1, 23'h000100, $urandom, ok);
      checks++;
      if (!ok || sdram_error !== 1'b1) begin
         errors++;
         $display("FAIL timeout_sticky ok=%0d got %b want 1", ok, sdram_error);
      end
      slv_en = 1'b0;
      @(negedge avm_clk);
      avm_rst = 1'b1;
      @(negedge avm_clk);
      avm_rst = 1'b0;
      checks++;
      if (sdram_error !== 1'b0) begin
         errors++;
         $display("FAIL timeout_clear got %b want 0", sdram_error);
      end
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL global_timeout cycles=%0d", cyc);
      $fatal(1, "bench timeout");
   end

   initial begin
      test_reset();
      test_basic_write();
      test_write_wait();
      test_read();
      test_reset_mid_read();
      test_simultaneous();
      test_random();
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
      test_timeout();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
